// File: rtl/cnt16_core_if.sv
// Control/data bundle for the cnt16_core up/down counter.
interface cnt16_core_if #(
  parameter int unsigned WIDTH = 16
);
  logic             i_mod_en;
  logic             i_tick;
  logic             i_ld;
  logic [WIDTH-1:0] i_ld_data;
  logic             i_dir;
  logic             i_oneshot;
  logic [WIDTH-1:0] i_cmp_data;
  logic [WIDTH-1:0] o_cnt;
  logic             o_match;
  logic             o_wrap;
  logic             o_busy;

  // Counter side: consumes controls, produces count and status.
  modport slave (
    input  i_mod_en, i_tick, i_ld, i_ld_data, i_dir, i_oneshot, i_cmp_data,
    output o_cnt, o_match, o_wrap, o_busy
  );

  // Controller side: drives controls, observes count and status.
  modport master (
    output i_mod_en, i_tick, i_ld, i_ld_data, i_dir, i_oneshot, i_cmp_data,
    input  o_cnt, o_match, o_wrap, o_busy
  );
endinterface

// File: rtl/cnt16_core.sv
// Tick-driven up/down counter with load, compare and one-shot wrap stop.
module cnt16_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic         i_sysclk,
  input  logic         i_sysrst,
  cnt16_core_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             match;
  logic             match_nxt;
  logic             wrap;
  logic             wrap_nxt;
  logic             busy;
  logic             busy_nxt;
  logic             step_c;
  logic [WIDTH-1:0] step_val_c;

  // Next state, next count and next pulse values; load outranks a tick.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    match_nxt  = 1'b0;
    wrap_nxt   = 1'b0;
    step_c     = (state == RUN) && bus.i_tick && !bus.i_ld;
    step_val_c = bus.i_dir ? WIDTH'(cnt + WIDTH'(1)) : WIDTH'(cnt - WIDTH'(1));

    if (bus.i_ld) begin
      cnt_nxt = bus.i_ld_data;
    end else if (step_c) begin
      cnt_nxt   = step_val_c;
      wrap_nxt  = bus.i_dir ? (cnt == CNT_MAX) : (cnt == CNT_ZERO);
      match_nxt = (step_val_c == bus.i_cmp_data);
    end

    unique case (state)
      IDLE: begin
        if (bus.i_mod_en) state_nxt = RUN;
      end
      RUN: begin
        if (!bus.i_mod_en)                 state_nxt = IDLE;
        else if (wrap_nxt && bus.i_oneshot) state_nxt = DONE;
      end
      DONE: begin
        if (!bus.i_mod_en)                 state_nxt = IDLE;
        else if (bus.i_ld)                 state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
      match <= 1'b0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      match <= match_nxt;
      wrap  <= wrap_nxt;
      busy  <= busy_nxt;
    end
  end

  assign bus.o_cnt   = cnt;
  assign bus.o_match = match;
  assign bus.o_wrap  = wrap;
  assign bus.o_busy  = busy;

endmodule
